// File: rtl/muldiv_ctrl.sv
// Sequencer between the control unit and the shared multiplier/divider: launches one
// operation, waits for its done (guarded by a watchdog), then strobes the result into HI/LO.
module muldiv_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic        divisor_zero,
  input  logic        mult_done,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic        div_done,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        mult_ctrl,
  output logic        div_ctrl,
  output logic        hi_load,
  output logic        lo_load,
  output logic [31:0] hi_in,
  output logic [31:0] lo_in,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        timeout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic             op_q;
  logic             sel_done;

  // Only the launched unit's done matters; the other unit's flag is ignored.
  assign sel_done = op_q ? div_done : mult_done;

  // NOTE: all state and outputs use non-blocking assignments so every register
  // samples the pre-edge values, giving true registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      op_q      <= 1'b0;
      mult_ctrl <= 1'b0;
      div_ctrl  <= 1'b0;
      hi_load   <= 1'b0;
      lo_load   <= 1'b0;
      hi_in     <= '0;
      lo_in     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each cycle; a state raises them for exactly one cycle.
      hi_load  <= 1'b0;
      lo_load  <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      timeout  <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            busy <= 1'b1;
            if (op && divisor_zero) begin
              state    <= FAULT;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state     <= RUN;
              mult_ctrl <= ~op;
              div_ctrl  <= op;
              count     <= '0;
            end
          end
        end

        RUN: begin
          // A done arriving on the watchdog's last cycle still counts as success.
          if (sel_done) begin
            hi_in     <= op_q ? div_hi : mult_hi;
            lo_in     <= op_q ? div_lo : mult_lo;
            mult_ctrl <= 1'b0;
            div_ctrl  <= 1'b0;
            hi_load   <= 1'b1;
            lo_load   <= 1'b1;
            done      <= 1'b1;
            state     <= WRITE;
          end else if (count == LAST_CNT) begin
            mult_ctrl <= 1'b0;
            div_ctrl  <= 1'b0;
            done      <= 1'b1;
            timeout   <= 1'b1;
            state     <= FAULT;
          end else begin
            count <= count + 1'b1;
          end
        end

        WRITE, FAULT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized self-checking bench for muldiv_ctrl; unit stubs present results computed
// from plain signed arithmetic and outcomes are predicted at the transaction level.
module tb_muldiv_ctrl;

  localparam int TIMEOUT = 64;

  logic        clock = 1'b0;
  logic        reset, start, op, divisor_zero, mult_done, div_done;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
  logic        mult_ctrl, div_ctrl, hi_load, lo_load, busy, done, div_zero, timeout;
  logic [31:0] hi_in, lo_in;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_hi  = '0;
  logic [31:0] last_lo  = '0;

  always #5 clock = ~clock;

  muldiv_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .divisor_zero(divisor_zero),
    .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_done(div_done), .div_hi(div_hi), .div_lo(div_lo),
    .mult_ctrl(mult_ctrl), .div_ctrl(div_ctrl), .hi_load(hi_load), .lo_load(lo_load),
    .hi_in(hi_in), .lo_in(lo_in), .busy(busy), .done(done),
    .div_zero(div_zero), .timeout(timeout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One transaction: lat = enable cycles until the unit raises done (> TIMEOUT means never in time).
  task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input bit noisy);
    logic [31:0] eh, el;
    longint      p;
    int          q, r;
    logic        sel_en, oth_en, hit;
    int          en_cycles;
    bit          ended;
    bit          ok;
    en_cycles = 0;
    ended     = 1'b0;
    ok        = (lat <= TIMEOUT);
    eh        = '0;
    el        = '0;
    if (!o) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      eh = p[63:32];
      el = p[31:0];
    end else if (b != 0) begin
      q  = $signed(a) / $signed(b);
      r  = $signed(a) % $signed(b);
      eh = r;
      el = q;
    end

    start = 1'b1; op = o; divisor_zero = (b == 0);
    @(negedge clock);
    start = 1'b0; op = 1'($urandom); divisor_zero = 1'($urandom);

    if (o && b == 0) begin
      check("dz_done", done, 1);
      check("dz_flag", div_zero, 1);
      check("dz_timeout", timeout, 0);
      check("dz_noload", {hi_load, lo_load}, 0);
      check("dz_enables", {mult_ctrl, div_ctrl}, 0);
      check("dz_hi_hold", hi_in, last_hi);
      check("dz_lo_hold", lo_in, last_lo);
      @(negedge clock);
      check("dz_idle", busy, 0);
      check("dz_pulse_end", {done, div_zero}, 0);
      check("dz_enables2", {mult_ctrl, div_ctrl}, 0);
      return;
    end

    for (int cyc = 0; cyc < 200 && !ended; cyc++) begin
      sel_en = o ? div_ctrl : mult_ctrl;
      oth_en = o ? mult_ctrl : div_ctrl;
      check("other_enable", oth_en, 0);
      if (sel_en) begin
        en_cycles++;
        check("run_busy", busy, 1);
        check("run_quiet", {hi_load, lo_load, done, timeout, div_zero}, 0);
        hit = (en_cycles == lat);
        mult_done = !o && hit;
        div_done  = o && hit;
        mult_hi   = (!o && hit) ? eh : $urandom;
        mult_lo   = (!o && hit) ? el : $urandom;
        div_hi    = (o && hit) ? eh : $urandom;
        div_lo    = (o && hit) ? el : $urandom;
        if (noisy) begin
          start = 1'($urandom); op = 1'($urandom); divisor_zero = 1'($urandom);
          if (!o) div_done = 1'($urandom);
          else    mult_done = 1'($urandom);
        end
        @(negedge clock);
      end else begin
        ended = 1'b1;
      end
    end
    check("no_hang", ended, 1);

    mult_done = 1'b0; div_done = 1'b0; start = 1'b0;
    check("enable_cycles", en_cycles, ok ? lat : TIMEOUT);
    check("pulse_done", done, 1);
    check("pulse_busy", busy, 1);
    check("pulse_no_dz", div_zero, 0);
    if (ok) begin
      check("load_strobes", {hi_load, lo_load}, 2'b11);
      check("no_timeout", timeout, 0);
      check("hi_in", hi_in, eh);
      check("lo_in", lo_in, el);
      last_hi = eh;
      last_lo = el;
    end else begin
      check("timeout_flag", timeout, 1);
      check("to_noload", {hi_load, lo_load}, 0);
      check("to_hi_hold", hi_in, last_hi);
      check("to_lo_hold", lo_in, last_lo);
    end
    @(negedge clock);
    check("idle_busy", busy, 0);
    check("idle_quiet", {hi_load, lo_load, done, timeout, div_zero, mult_ctrl, div_ctrl}, 0);
    check("idle_hi_hold", hi_in, last_hi);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic        ro;
    logic [31:0] ra, rb;
    int          rl;
    reset = 1'b1; start = 1'b0; op = 1'b0; divisor_zero = 1'b0;
    mult_done = 1'b0; div_done = 1'b0;
    mult_hi = '0; mult_lo = '0; div_hi = '0; div_lo = '0;
    repeat (3) @(negedge clock);
    check("rst_outputs", {mult_ctrl, div_ctrl, hi_load, lo_load, busy, done, div_zero, timeout}, 0);
    check("rst_data", {hi_in, lo_in}, 0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_after_rst", busy, 0);

    do_op(1'b0, 32'd7, -32'sd3, 34, 1'b0);
    do_op(1'b1, 32'd100, 32'd7, 33, 1'b0);
    do_op(1'b1, 32'd55, 32'd0, 1, 1'b0);
    do_op(1'b0, 32'd9, 32'd0, 5, 1'b0);
    do_op(1'b0, 32'd11, 32'd13, 1000, 1'b0);
    do_op(1'b1, 32'd11, 32'd13, 1000, 1'b0);
    do_op(1'b0, -32'sd5, 32'd1000, TIMEOUT, 1'b0);
    do_op(1'b1, -32'sd77, 32'd5, TIMEOUT + 1, 1'b0);
    do_op(1'b0, 32'd123, 32'd456, 20, 1'b1);
    do_op(1'b1, 32'd9999, -32'sd31, 30, 1'b1);

    // start held high re-launches right after the done pulse; then reset lands mid-MULT
    start = 1'b1; op = 1'b0; divisor_zero = 1'b0;
    @(negedge clock);
    check("rl_en_first", mult_ctrl, 1);
    mult_done = 1'b1; mult_hi = 32'h0000_1234; mult_lo = 32'h0000_5678;
    @(negedge clock);
    mult_done = 1'b0;
    check("rl_done", done, 1);
    check("rl_loads", {hi_load, lo_load}, 2'b11);
    check("rl_data", {hi_in, lo_in}, 64'h0000_1234_0000_5678);
    @(negedge clock);
    check("rl_idle_gap", {busy, mult_ctrl}, 0);
    @(negedge clock);
    start = 1'b0;
    check("rl_relaunch", {busy, mult_ctrl}, 2'b11);
    for (int i = 2; i <= 10; i++) begin
      @(negedge clock);
      check("rl_en_hold", mult_ctrl, 1);
    end
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_enable", {mult_ctrl, div_ctrl}, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_noload", {hi_load, lo_load, done}, 0);
    check("mid_rst_data", {hi_in, lo_in}, 0);
    reset = 1'b0;
    last_hi = '0;
    last_lo = '0;
    @(negedge clock);
    check("post_rst_idle", {busy, mult_ctrl}, 0);

    for (int n = 0; n < 25; n++) begin
      ro = 1'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (ro && rb == 32'hFFFF_FFFF) rb = 32'd3;
      rl = ($urandom_range(0, 4) == 0) ? $urandom_range(TIMEOUT - 4, TIMEOUT + 6)
                                       : $urandom_range(1, 40);
      do_op(ro, ra, rb, rl, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
